// File: rtl/avalon_interval_timer_pkg.sv
// Register map and bit positions for the Avalon-MM interval timer.
package avalon_interval_timer_pkg;

  typedef enum logic [2:0] {
    ADDR_STATUS  = 3'd0,
    ADDR_CONTROL = 3'd1,
    ADDR_PERIODL = 3'd2,
    ADDR_PERIODH = 3'd3,
    ADDR_SNAPL   = 3'd4,
    ADDR_SNAPH   = 3'd5
  } reg_addr_e;

  localparam int unsigned CTL_ITO   = 0;
  localparam int unsigned CTL_CONT  = 1;
  localparam int unsigned CTL_START = 2;
  localparam int unsigned CTL_STOP  = 3;

  localparam int unsigned ST_TO  = 0;
  localparam int unsigned ST_RUN = 1;

endpackage

// File: rtl/interval_timer_core.sv
// Down-counter with run/cont state; reloads from period and flags a timeout
// on the edge after reaching zero.
module interval_timer_core
  import avalon_interval_timer_pkg::*;
#(
  parameter int unsigned          COUNT_W    = 32,
  parameter logic [COUNT_W-1:0]   INIT_COUNT = '0,
  parameter bit                   AUTO_START = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] period,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               ctl_write,
  input  logic               start,
  input  logic               stop,
  input  logic               cont_value,
  output logic [COUNT_W-1:0] count,
  output logic               run,
  output logic               cont,
  output logic               timeout
);

  // Timeout fires on the edge where a running counter sits at zero.
  always_comb begin
    timeout = run && (count == '0);
  end

  // Counter, run and cont state; a period load overrides any reload or control write.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= INIT_COUNT;
      run   <= AUTO_START;
      cont  <= AUTO_START;
    end else begin
      if (load) begin
        count <= load_value;
        run   <= 1'b0;
      end else begin
        if (run) begin
          count <= timeout ? period : count - COUNT_W'(1);
        end
        // Explicit control beats the one-shot auto stop; stop beats start.
        if (ctl_write && stop) begin
          run <= 1'b0;
        end else if (ctl_write && start) begin
          run <= 1'b1;
        end else if (timeout && !cont) begin
          run <= 1'b0;
        end
      end
      if (ctl_write) begin
        cont <= cont_value;
      end
    end
  end

endmodule

// File: rtl/avalon_interval_timer.sv
// Avalon-MM 16-bit slave wrapper: period/control/status registers,
// coherent counter snapshot, registered read mux and interrupt.
module avalon_interval_timer
  import avalon_interval_timer_pkg::*;
#(
  parameter int unsigned COUNT_W      = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h1387,
  parameter bit          AUTO_START   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam logic [COUNT_W-1:0] INIT_VALUE = RESET_PERIOD[COUNT_W-1:0];

  logic               wr_en;
  logic               period_wr;
  logic               ctl_write;
  logic               status_wr;
  logic               snap_wr;
  logic [COUNT_W-1:0] period;
  logic [COUNT_W-1:0] period_next;
  logic [COUNT_W-1:0] snapshot;
  logic [COUNT_W-1:0] count;
  logic               run;
  logic               cont;
  logic               timeout;
  logic               to;
  logic               ito;
  logic [31:0]        period_ext;
  logic [31:0]        snap_ext;
  logic [15:0]        read_value;

  // Decode bus writes and build the period including the half being written.
  always_comb begin
    wr_en       = chipselect && !write_n;
    status_wr   = wr_en && (address == ADDR_STATUS);
    ctl_write   = wr_en && (address == ADDR_CONTROL);
    period_wr   = wr_en && ((address == ADDR_PERIODL) || (address == ADDR_PERIODH));
    snap_wr     = wr_en && ((address == ADDR_SNAPL) || (address == ADDR_SNAPH));
    period_next = period;
    if (address == ADDR_PERIODL) begin
      period_next[15:0] = writedata;
    end else begin
      period_next[COUNT_W-1:16] = writedata[COUNT_W-17:0];
    end
  end

  interval_timer_core #(
    .COUNT_W    (COUNT_W),
    .INIT_COUNT (INIT_VALUE),
    .AUTO_START (AUTO_START)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .period     (period),
    .load       (period_wr),
    .load_value (period_next),
    .ctl_write  (ctl_write),
    .start      (writedata[CTL_START]),
    .stop       (writedata[CTL_STOP]),
    .cont_value (writedata[CTL_CONT]),
    .count      (count),
    .run        (run),
    .cont       (cont),
    .timeout    (timeout)
  );

  // Period register.
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= INIT_VALUE;
    end else if (period_wr) begin
      period <= period_next;
    end
  end

  // Timeout flag (set wins over a STATUS clear) and interrupt enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      to  <= 1'b0;
      ito <= 1'b0;
    end else begin
      if (timeout) begin
        to <= 1'b1;
      end else if (status_wr) begin
        to <= 1'b0;
      end
      if (ctl_write) begin
        ito <= writedata[CTL_ITO];
      end
    end
  end

  // Snapshot captures the whole counter at once so both halves match.
  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot <= INIT_VALUE;
    end else if (snap_wr) begin
      snapshot <= count;
    end
  end

  // Read mux for the currently presented address.
  always_comb begin
    period_ext = 32'(period);
    snap_ext   = 32'(snapshot);
    read_value = '0;
    case (address)
      ADDR_STATUS: begin
        read_value[ST_RUN] = run;
        read_value[ST_TO]  = to;
      end
      ADDR_CONTROL: begin
        read_value[CTL_CONT] = cont;
        read_value[CTL_ITO]  = ito;
      end
      ADDR_PERIODL: read_value = period_ext[15:0];
      ADDR_PERIODH: read_value = period_ext[31:16];
      ADDR_SNAPL:   read_value = snap_ext[15:0];
      ADDR_SNAPH:   read_value = snap_ext[31:16];
      default:      read_value = '0;
    endcase
  end

  // Registered read data, refreshed every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= read_value;
    end
  end

  // Interrupt straight from the flag and enable flops.
  always_comb begin
    irq = to && ito;
  end

endmodule

// File: tb/tb_avalon_interval_timer.sv
// Self-checking bench for avalon_interval_timer: reference model compared
// every cycle, a register readback table, and scripted timing sequences.
module tb_avalon_interval_timer;
  import avalon_interval_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'h0;
  logic [15:0] readdata;
  logic        irq;
  logic [15:0] readdata1;
  logic        irq1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state (default-parameter instance only)
  logic [31:0] m_count, m_period, m_snap;
  logic        m_run, m_cont, m_to, m_ito;
  logic [15:0] m_rd;

  avalon_interval_timer #(
    .COUNT_W      (32),
    .RESET_PERIOD (32'h1387),
    .AUTO_START   (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  avalon_interval_timer #(
    .COUNT_W      (20),
    .RESET_PERIOD (32'h0012_3456),
    .AUTO_START   (1'b1)
  ) dut_auto (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata1),
    .irq        (irq1)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {14'd0, m_run, m_to};
      3'd1:    return {14'd0, m_cont, m_ito};
      3'd2:    return m_period[15:0];
      3'd3:    return m_period[31:16];
      3'd4:    return m_snap[15:0];
      3'd5:    return m_snap[31:16];
      default: return 16'h0;
    endcase
  endfunction

  // One clock edge of the register-level behaviour.
  task automatic model_step();
    logic [31:0] n_count, n_period, n_snap;
    logic        n_run, n_cont, n_to, n_ito, wr, expired;
    if (reset) begin
      m_count = 32'h1387; m_period = 32'h1387; m_snap = 32'h1387;
      m_run = 1'b0; m_cont = 1'b0; m_to = 1'b0; m_ito = 1'b0; m_rd = 16'h0;
      return;
    end
    wr = chipselect && !write_n;
    expired = m_run && (m_count == 0);
    n_count = m_count; n_period = m_period; n_snap = m_snap;
    n_run = m_run; n_cont = m_cont; n_to = m_to; n_ito = m_ito;
    if (m_run) n_count = expired ? m_period : m_count - 32'd1;
    if (expired) begin
      n_to = 1'b1;
      if (!m_cont) n_run = 1'b0;
    end
    if (wr) begin
      case (address)
        3'd0: if (!expired) n_to = 1'b0;
        3'd1: begin
          n_cont = writedata[1];
          n_ito  = writedata[0];
          if (writedata[3]) n_run = 1'b0;
          else if (writedata[2]) n_run = 1'b1;
        end
        3'd2: begin
          n_period = {m_period[31:16], writedata};
          n_count = n_period; n_run = 1'b0;
        end
        3'd3: begin
          n_period = {writedata, m_period[15:0]};
          n_count = n_period; n_run = 1'b0;
        end
        3'd4, 3'd5: n_snap = m_count;
        default: ;
      endcase
    end
    m_rd = model_read(address);
    m_count = n_count; m_period = n_period; m_snap = n_snap;
    m_run = n_run; m_cont = n_cont; m_to = n_to; m_ito = n_ito;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("model_readdata", {16'h0, readdata}, {16'h0, m_rd});
    check("model_irq", {31'h0, irq}, {31'h0, m_to & m_ito});
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a; chipselect = 1'b0; write_n = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd(ADDR_STATUS);
  endtask

  task automatic wait_irq(input int max, output int n);
    n = 0;
    address = ADDR_STATUS; chipselect = 1'b0; write_n = 1'b1;
    do begin
      tick();
      n++;
    end while (!irq && n < max);
  endtask

  task automatic do_reset();
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = ADDR_STATUS;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n, start_cyc, r;
    logic [2:0]  ra;
    logic [15:0] rdat;

    vecs[0]  = '{ADDR_PERIODL, 16'hBEEF, ADDR_PERIODL, 16'hBEEF};
    vecs[1]  = '{ADDR_PERIODH, 16'h1234, ADDR_PERIODH, 16'h1234};
    vecs[2]  = '{ADDR_CONTROL, 16'h000F, ADDR_CONTROL, 16'h0003};
    vecs[3]  = '{ADDR_STATUS,  16'hFFFF, ADDR_STATUS,  16'h0000};
    vecs[4]  = '{ADDR_CONTROL, 16'h0004, ADDR_CONTROL, 16'h0000};
    vecs[5]  = '{ADDR_STATUS,  16'h0000, ADDR_STATUS,  16'h0002};
    vecs[6]  = '{ADDR_PERIODL, 16'h0010, ADDR_STATUS,  16'h0000};
    vecs[7]  = '{3'd6,         16'hFFFF, 3'd6,         16'h0000};
    vecs[8]  = '{3'd7,         16'hFFFF, 3'd7,         16'h0000};
    vecs[9]  = '{ADDR_PERIODH, 16'hFFFF, ADDR_PERIODH, 16'hFFFF};
    vecs[10] = '{ADDR_CONTROL, 16'h0004, ADDR_STATUS,  16'h0002};
    vecs[11] = '{ADDR_CONTROL, 16'h000C, ADDR_STATUS,  16'h0000};

    // Reset defaults
    tick();
    tick();
    reset = 1'b0;
    check("reset_readdata", {16'h0, readdata}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    rd(ADDR_STATUS);
    check("reset_status", {16'h0, readdata}, 32'h0);
    check("auto_status", {16'h0, readdata1}, 32'h2);
    rd(ADDR_PERIODL);
    check("reset_periodl", {16'h0, readdata}, 32'h1387);
    check("auto_periodl", {16'h0, readdata1}, 32'h3456);
    rd(ADDR_PERIODH);
    check("reset_periodh", {16'h0, readdata}, 32'h0);
    check("auto_periodh", {16'h0, readdata1}, 32'h2);

    // Register readback table
    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].wr_addr, vecs[i].wr_data);
      rd(vecs[i].rd_addr);
      check($sformatf("table[%0d]", i), {16'h0, readdata}, {16'h0, vecs[i].exp});
    end

    // Continuous mode, period 4
    wr(ADDR_PERIODL, 16'd4);
    wr(ADDR_PERIODH, 16'd0);
    wr(ADDR_CONTROL, 16'h0007);
    wait_irq(20, n);
    check("cont_first_timeout", n, 5);
    wr(ADDR_STATUS, 16'h0);
    check("cont_irq_cleared", {31'h0, irq}, 32'h0);
    wait_irq(20, n);
    check("cont_second_timeout", n, 4);
    idle(4);
    wr(ADDR_STATUS, 16'h0);
    check("status_wr_vs_timeout", {31'h0, irq}, 32'h1);
    wr(ADDR_CONTROL, 16'h0008);
    wr(ADDR_STATUS, 16'h0);

    // One-shot, period 3
    wr(ADDR_PERIODL, 16'd3);
    wr(ADDR_PERIODH, 16'd0);
    wr(ADDR_CONTROL, 16'h0005);
    wait_irq(20, n);
    check("oneshot_timeout", n, 4);
    idle(20);
    rd(ADDR_STATUS);
    check("oneshot_status", {16'h0, readdata}, 32'h1);
    wr(ADDR_STATUS, 16'h0);
    idle(20);
    check("oneshot_no_second", {31'h0, irq}, 32'h0);
    wr(ADDR_SNAPL, 16'h0);
    rd(ADDR_SNAPL);
    check("oneshot_hold_snapl", {16'h0, readdata}, 32'h3);
    rd(ADDR_SNAPH);
    check("oneshot_hold_snaph", {16'h0, readdata}, 32'h0);

    // Long period 0x0001_0000 with a mid-count snapshot
    wr(ADDR_PERIODL, 16'h0000);
    wr(ADDR_PERIODH, 16'h0001);
    wr(ADDR_CONTROL, 16'h0005);
    start_cyc = cyc;
    idle(999);
    wr(ADDR_SNAPH, 16'h0);
    rd(ADDR_SNAPL);
    check("long_snapl", {16'h0, readdata}, 32'hFC19);
    rd(ADDR_SNAPH);
    check("long_snaph", {16'h0, readdata}, 32'h0);
    wait_irq(70000, n);
    check("long_timeout_cycles", cyc - start_cyc, 65537);
    rd(ADDR_STATUS);
    check("long_status", {16'h0, readdata}, 32'h1);

    // Reset in the middle of a continuous count with irq pending
    wr(ADDR_PERIODL, 16'h0010);
    wr(ADDR_PERIODH, 16'h0000);
    wr(ADDR_CONTROL, 16'h0007);
    idle(30);
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    do_reset();
    check("midreset_readdata", {16'h0, readdata}, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    rd(ADDR_STATUS);
    check("midreset_status", {16'h0, readdata}, 32'h0);
    check("midreset_auto_status", {16'h0, readdata1}, 32'h2);
    rd(ADDR_PERIODL);
    check("midreset_periodl", {16'h0, readdata}, 32'h1387);
    rd(ADDR_SNAPL);
    check("midreset_snapl", {16'h0, readdata}, 32'h1387);
    wr(ADDR_SNAPL, 16'h0);
    rd(ADDR_SNAPL);
    check("midreset_counter", {16'h0, readdata}, 32'h1387);

    // Randomized traffic against the model
    wr(ADDR_PERIODL, 16'd6);
    wr(ADDR_PERIODH, 16'd0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 299);
      ra = 3'($urandom_range(0, 7));
      if (r == 0) begin
        do_reset();
      end else if (r < 90) begin
        case (ra)
          3'd2: rdat = 16'($urandom_range(0, 12));
          3'd3: rdat = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h0;
          3'd1: rdat = 16'($urandom_range(0, 15));
          default: rdat = 16'($urandom);
        endcase
        wr(ra, rdat);
      end else begin
        rd(ra);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_interval_timer.md
# avalon_interval_timer

Parametrised Avalon-MM interval timer, the next-generation replacement for the fixed-period system timer in the alarm system. It adds a software-writable period of up to 32 bits, start/stop control, one-shot or continuous mode, and a coherent counter snapshot. It sits on the Nios II data master as a 16-bit slave and drives one interrupt line.

## Interface
- COUNT_W, 32: counter/period width. Legal range 17..32; the period is split into two 16-bit halves.
- RESET_PERIOD, 32'h1387: period and counter value after reset. Truncated to COUNT_W bits.
- AUTO_START, 0: if 1, `running` comes out of reset set and `cont` comes out of reset set.

- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  16  write data.
- readdata  out  16  registered read data; reset value 0.
- irq  out  1  equals `to & ito`; reset value 0.

## Operation
- Register map:
  - 0 STATUS: bit1 `run` (read-only); bit0 `to`. Any write clears `to`.
  - 1 CONTROL: bit3 `stop`, bit2 `start` (write-only pulses, read as 0); bit1 `cont`; bit0 `ito`.
  - 2 PERIODL: period[15:0].
  - 3 PERIODH: period[COUNT_W-1:16]; unused bits read as 0.
  - 4 SNAPL: snapshot[15:0].
  - 5 SNAPH: snapshot[COUNT_W-1:16].
  - 6 and 7 read as 0; writes to them are ignored.
- Counter:
  - While `run`=1, the counter decrements by 1 per clk.
  - When `run`=1 and counter==0, on the next edge: counter <= period, `to` <= 1, and if `cont`=0 then `run` <= 0.
  - The timeout period is therefore period+1 cycles.
- Period write (offset 2 or 3):
  - Updates that half of the period register.
  - Forces `run` <= 0.
  - Counter <= the new period value, including the just-written half.
- START/STOP:
  - A CONTROL write with start=1 sets `run`.
  - A CONTROL write with stop=1 clears `run`.
  - If both are 1, stop wins.
  - `cont` and `ito` update on every CONTROL write.
- Snapshot: any write to offset 4 or 5 copies the full counter (pre-edge value) into the snapshot register, so SNAPL and SNAPH always come from the same cycle.
- Simultaneous events:
  - Timeout in the same cycle as a STATUS write: `to` stays 1 (set wins).
  - Timeout in the same cycle as a period write: the period write wins. The counter loads the new period and `run`=0, but `to` is still set.
  - Timeout in the same cycle as a stop write: counter reloads, `to` is set, `run`=0.
- Reset (including mid-count):
  - counter = period = snapshot = RESET_PERIOD.
  - `to` = 0, `ito` = 0, readdata = 0.
  - `run` and `cont` = AUTO_START.

## Timing
- readdata is registered from the current address every cycle, independent of read strobes. Data for address A is valid one clk after A is presented; reads have no side effects.
- Register writes take effect on the clk edge where the write strobe is high. Readback on the following cycle shows the new value.
- irq is combinational from the `to` and `ito` flops: it asserts one cycle after the zero-cycle edge and deasserts in the cycle after the STATUS write.
- A START write at edge N makes the counter's first decrement happen at edge N+1.

## Structure
- Package `avalon_interval_timer_pkg`:
  - Register offsets: ADDR_STATUS through ADDR_SNAPH.
  - CONTROL bit indices: CTL_ITO, CTL_CONT, CTL_START, CTL_STOP.
  - STATUS bit indices: ST_TO, ST_RUN.
- Sub-module `interval_timer_core`: the counter, `run`/`cont` logic and timeout pulse, with load/start/stop inputs.
- The top level holds the register file, snapshot, read mux and irq.

## Test plan
- Reset with defaults: readdata=0, irq=0, `run`=0. Reading STATUS returns 0. Reading PERIODL returns 16'h1387 one cycle after the address is presented.
- Write PERIODL=4, PERIODH=0, CONTROL=4'b0111 (start, cont, ito): `to`/irq rise every 5 cycles. A STATUS write clears irq on the next cycle.
- One-shot: period=3, CONTROL=4'b0101: exactly one timeout, then `run`=0 with the counter holding 3.
- Period 32'h0001_0000: the timeout occurs after 65537 cycles. A snapshot at an arbitrary cycle gives SNAPH:SNAPL equal to the counter value in the write cycle.
- Write CONTROL=4'b1100 (start and stop together) → `run`=0. Perform a STATUS write in the same cycle as a timeout → `to` remains 1.
- Assert reset mid-count with `run`=1 → next cycle: counter=RESET_PERIOD, `run`=0, irq=0. Repeat with AUTO_START=1 → `run`=1.
